// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter slice.
//   shift_op_t        : op encoding on req_op (SLL/SRL/SRA/reserved)
//   shift_arb_state_t : arbiter FSM state
//   SHIFT_N           : datapath width (only 32 supported)
//   SHIFT_SHAMT_W     : shift amount width, $clog2(SHIFT_N)
package shift_pkg;

  localparam int SHIFT_N       = 32;
  localparam int SHIFT_SHAMT_W = $clog2(SHIFT_N);

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'd0,
    SHIFT_SRL  = 2'd1,
    SHIFT_SRA  = 2'd2,
    SHIFT_RSVD = 2'd3
  } shift_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } shift_arb_state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shift datapath: three shifters plus an op-select mux.
//   in    : operand
//   shamt : shift amount
//   op    : SLL / SRL / SRA / reserved
//   out   : shifted result (reserved op passes in through unchanged)
//   err   : high for the reserved op
module shift_core
  import shift_pkg::*;
(
  input  logic [SHIFT_N-1:0]       in,
  input  logic [SHIFT_SHAMT_W-1:0] shamt,
  input  shift_op_t                op,
  output logic [SHIFT_N-1:0]       out,
  output logic                     err
);

  logic [SHIFT_N-1:0] sll_out;
  logic [SHIFT_N-1:0] srl_out;
  logic [SHIFT_N-1:0] sra_out;

  shift_left_logical     u_sll (.in(in), .shamt(shamt), .out(sll_out));
  shift_right_logical    u_srl (.in(in), .shamt(shamt), .out(srl_out));
  shift_right_arithmetic u_sra (.in(in), .shamt(shamt), .out(sra_out));

  always_comb begin
    out = in;
    err = 1'b0;
    case (op)
      SHIFT_SLL: out = sll_out;
      SHIFT_SRL: out = srl_out;
      SHIFT_SRA: out = sra_out;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_left_logical.sv
// Logical left shift, zero fill from the LSB.
//   in    : operand
//   shamt : shift amount
//   out   : in << shamt
module shift_left_logical
  import shift_pkg::*;
(
  input  logic [SHIFT_N-1:0]       in,
  input  logic [SHIFT_SHAMT_W-1:0] shamt,
  output logic [SHIFT_N-1:0]       out
);

  assign out = in << shamt;

endmodule

// File: rtl/shift_right_arithmetic.sv
// Arithmetic right shift, fill with the operand sign bit.
//   in    : operand
//   shamt : shift amount
//   out   : in >>> shamt (signed)
module shift_right_arithmetic
  import shift_pkg::*;
(
  input  logic [SHIFT_N-1:0]       in,
  input  logic [SHIFT_SHAMT_W-1:0] shamt,
  output logic [SHIFT_N-1:0]       out
);

  assign out = $unsigned($signed(in) >>> shamt);

endmodule

// File: rtl/shift_right_logical.sv
// Logical right shift, zero fill from the MSB.
//   in    : operand
//   shamt : shift amount
//   out   : in >> shamt
module shift_right_logical
  import shift_pkg::*;
(
  input  logic [SHIFT_N-1:0]       in,
  input  logic [SHIFT_SHAMT_W-1:0] shamt,
  output logic [SHIFT_N-1:0]       out
);

  assign out = in >> shamt;

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-bit shift datapath.
// One transaction in flight, registered result, 1 result/cycle when the
// consumer keeps rsp_ready high.
//   clk, rst_n        : clock, async active-low reset
//   req_valid/ready   : per-port request handshake
//   req_op/in/shamt   : per-port request payload
//   rsp_valid/ready   : response handshake
//   rsp_data/id/err   : registered result, owning port, reserved-op flag
//
// state  | meaning
// S_IDLE | no result held; granted port may be accepted
// S_HOLD | result registered, waiting for rsp_ready
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N    = SHIFT_N,
  parameter int NREQ = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][1:0]                req_op,
  input  logic [NREQ-1:0][N-1:0]              req_in,
  input  logic [NREQ-1:0][SHIFT_SHAMT_W-1:0]  req_shamt,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [N-1:0]                        rsp_data,
  output logic                                rsp_id,
  output logic                                rsp_err
);

  shift_arb_state_t state_q, state_d;
  logic             rr_ptr;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [N-1:0]     core_out;
  logic             core_err;

  // Contended: follow the pointer. Otherwise the single valid port wins.
  assign grant      = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
  // Back-to-back: a held result that is consumed this cycle frees the slot.
  assign can_accept = (state_q == S_IDLE) || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && req_valid[grant]) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept    = |req_ready;
  assign rsp_valid = (state_q == S_HOLD);

  shift_core u_core (
    .in    (req_in[grant]),
    .shamt (req_shamt[grant]),
    .op    (shift_op_t'(req_op[grant])),
    .out   (core_out),
    .err   (core_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_HOLD;
      S_HOLD:  if (rsp_ready && !accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rr_ptr   <= ~grant;
      rsp_data <= core_out;
      rsp_id   <= grant;
      rsp_err  <= core_err;
    end
  end

endmodule
